load_store_unit: RTL and testbench

- Sits directly upstream of the 1024 x 18 data memory. Sole master of the memory's address, data_input and data_memo_str pins.
- Accepts load/store requests from the execute stage over a valid/ready handshake and computes the effective address as base + sign-extended offset.
- Sequences the memory write or read, waits out the read latency, and returns one response per request to writeback over a valid/ready handshake.

---
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer sitting in front of the 1024 x 18 data memory.
// Accepts one request at a time, drives the memory pins and returns one response per request.
module load_store_unit #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 18,
    parameter int OFFSET_WIDTH = 6,
    parameter int DEST_WIDTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_base,
    input  logic [OFFSET_WIDTH-1:0] req_offset,
    input  logic [DATA_WIDTH-1:0]   req_store_data,
    input  logic [DEST_WIDTH-1:0]   req_dest,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_data_input,
    output logic                    mem_data_memo_str,
    input  logic [DATA_WIDTH-1:0]   mem_data_output,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_is_load,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [DEST_WIDTH-1:0]   rsp_dest,
    output logic                    rsp_error
);

    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [DEST_WIDTH-1:0]   dest_q, dest_d;
    logic                    isLoad_q, isLoad_d;
    logic                    error_q, error_d;
    logic [1:0]              cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]   offsetExt;
    logic [DATA_WIDTH-1:0]   effAddr;
    logic                    eaError;

    // Any set bit above the memory address range makes the access illegal, wrap-around included.
    assign offsetExt = {{(DATA_WIDTH-OFFSET_WIDTH){req_offset[OFFSET_WIDTH-1]}}, req_offset};
    assign effAddr   = req_base + offsetExt;
    assign eaError   = |effAddr[DATA_WIDTH-1:ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            dest_q   <= '0;
            isLoad_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            dest_q   <= dest_d;
            isLoad_q <= isLoad_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        dest_d            = dest_q;
        isLoad_d          = isLoad_q;
        error_d           = error_q;
        cnt_d             = cnt_q;
        req_ready         = 1'b0;
        mem_data_memo_str = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = effAddr[ADDR_WIDTH-1:0];
                    wdata_d  = req_store_data;
                    dest_d   = req_dest;
                    isLoad_d = ~req_write;
                    error_d  = eaError;
                    rdata_d  = '0;
                    if (eaError) begin
                        state_d = RESP;
                    end else if (req_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ_WAIT;
                        cnt_d   = 2'(READ_LATENCY);
                    end
                end
            end
            WRITE: begin
                // A reset landing in this cycle must suppress the write at the closing edge.
                mem_data_memo_str = ~reset;
                state_d           = RESP;
            end
            READ_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rdata_d = mem_data_output;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_address    = addr_q;
    assign mem_data_input = wdata_q;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_is_load    = isLoad_q;
    assign rsp_data       = rdata_q;
    assign rsp_dest       = dest_q;
    assign rsp_error      = error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at read latency 1 and one at read latency 3,
// each backed by a behavioural data memory whose read data appears READ_LATENCY cycles after the address.
module tb_load_store_unit;

    localparam int AW = 10;
    localparam int DW = 18;
    localparam int OW = 6;
    localparam int RW = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    // Fast instance (READ_LATENCY = 1)
    logic          reqValid, reqReady, reqWrite;
    logic [DW-1:0] reqBase, reqStoreData;
    logic [OW-1:0] reqOffset;
    logic [RW-1:0] reqDest;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memDataInput, memDataOutput;
    logic          memStr;
    logic          rspValid, rspReady, rspIsLoad, rspError;
    logic [DW-1:0] rspData;
    logic [RW-1:0] rspDest;

    // Slow instance (READ_LATENCY = 3)
    logic          reqValid3, reqReady3, reqWrite3;
    logic [DW-1:0] reqBase3, reqStoreData3;
    logic [OW-1:0] reqOffset3;
    logic [RW-1:0] reqDest3;
    logic [AW-1:0] memAddress3;
    logic [DW-1:0] memDataInput3, memDataOutput3;
    logic          memStr3;
    logic          rspValid3, rspReady3, rspIsLoad3, rspError3;
    logic [DW-1:0] rspData3;
    logic [RW-1:0] rspDest3;

    logic [DW-1:0] memFast [0:1023];
    logic [DW-1:0] memSlow [0:1023];
    logic [AW-1:0] slowPipe0, slowPipe1;
    int            writeCount = 0;
    int            testCount  = 0;
    int            failCount  = 0;

    load_store_unit #(.READ_LATENCY(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
        .req_base(reqBase), .req_offset(reqOffset), .req_store_data(reqStoreData), .req_dest(reqDest),
        .mem_address(memAddress), .mem_data_input(memDataInput), .mem_data_memo_str(memStr),
        .mem_data_output(memDataOutput),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_is_load(rspIsLoad),
        .rsp_data(rspData), .rsp_dest(rspDest), .rsp_error(rspError)
    );

    load_store_unit #(.READ_LATENCY(3)) dutSlow (
        .clock(clock), .reset(reset),
        .req_valid(reqValid3), .req_ready(reqReady3), .req_write(reqWrite3),
        .req_base(reqBase3), .req_offset(reqOffset3), .req_store_data(reqStoreData3), .req_dest(reqDest3),
        .mem_address(memAddress3), .mem_data_input(memDataInput3), .mem_data_memo_str(memStr3),
        .mem_data_output(memDataOutput3),
        .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_is_load(rspIsLoad3),
        .rsp_data(rspData3), .rsp_dest(rspDest3), .rsp_error(rspError3)
    );

    // Latency-1 memory: data for the presented address is valid within the same cycle.
    always @(posedge clock) begin
        if (memStr) begin
            memFast[memAddress] <= memDataInput;
            writeCount          <= writeCount + 1;
        end
    end
    assign memDataOutput = memFast[memAddress];

    // Latency-3 memory: the address passes through two registers before the array is read.
    always @(posedge clock) begin
        slowPipe0 <= memAddress3;
        slowPipe1 <= slowPipe0;
        if (memStr3) memSlow[memAddress3] <= memDataInput3;
    end
    assign memDataOutput3 = memSlow[slowPipe1];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle; returns one cycle after the accept edge.
    task automatic applyStimulus(input bit slow, input bit write, input logic [DW-1:0] base,
                                 input logic [OW-1:0] offset, input logic [DW-1:0] data,
                                 input logic [RW-1:0] dest);
        if (slow) begin
            reqValid3 = 1'b1; reqWrite3 = write; reqBase3 = base;
            reqOffset3 = offset; reqStoreData3 = data; reqDest3 = dest;
        end else begin
            reqValid = 1'b1; reqWrite = write; reqBase = base;
            reqOffset = offset; reqStoreData = data; reqDest = dest;
        end
        step();
        reqValid  = 1'b0;
        reqValid3 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            memFast[i] = '0;
            memSlow[i] = '0;
        end
        slowPipe0 = '0; slowPipe1 = '0;
        reqValid = 0; reqWrite = 0; reqBase = '0; reqOffset = '0; reqStoreData = '0; reqDest = '0;
        reqValid3 = 0; reqWrite3 = 0; reqBase3 = '0; reqOffset3 = '0; reqStoreData3 = '0; reqDest3 = '0;
        rspReady = 1'b1; rspReady3 = 1'b1;
        reset = 1'b1;
        step();
        step();

        checkOutput("rst_rspValid", 32'(rspValid), 0);
        checkOutput("rst_reqReady", 32'(reqReady), 1);
        checkOutput("rst_memAddress", 32'(memAddress), 0);
        checkOutput("rst_memDataInput", 32'(memDataInput), 0);
        checkOutput("rst_memStr", 32'(memStr), 0);
        checkOutput("rst_rspData", 32'(rspData), 0);
        checkOutput("rst_rspDest", 32'(rspDest), 0);
        checkOutput("rst_rspIsLoad", 32'(rspIsLoad), 0);
        checkOutput("rst_rspError", 32'(rspError), 0);
        reset = 1'b0;
        step();

        // Store 0x2AAAA to 0x10 + 2 = 0x012
        applyStimulus(0, 1, 18'h00010, 6'd2, 18'h2AAAA, 4'd3);
        checkOutput("st_memStr", 32'(memStr), 1);
        checkOutput("st_memAddress", 32'(memAddress), 32'h012);
        checkOutput("st_memDataInput", 32'(memDataInput), 32'h2AAAA);
        checkOutput("st_reqReady", 32'(reqReady), 0);
        checkOutput("st_rspValidEarly", 32'(rspValid), 0);
        step();
        checkOutput("st_rspValid", 32'(rspValid), 1);
        checkOutput("st_rspIsLoad", 32'(rspIsLoad), 0);
        checkOutput("st_rspData", 32'(rspData), 0);
        checkOutput("st_rspError", 32'(rspError), 0);
        checkOutput("st_rspDest", 32'(rspDest), 3);
        checkOutput("st_memStrResp", 32'(memStr), 0);
        checkOutput("st_memWritten", 32'(memFast[10'h012]), 32'h2AAAA);
        checkOutput("st_writeCount", 32'(writeCount), 1);
        step();
        checkOutput("st_idleReady", 32'(reqReady), 1);
        checkOutput("st_idleRspValid", 32'(rspValid), 0);

        // Load it back
        applyStimulus(0, 0, 18'h00010, 6'd2, 18'h0, 4'd5);
        checkOutput("ld_memStr", 32'(memStr), 0);
        checkOutput("ld_rspValidEarly", 32'(rspValid), 0);
        checkOutput("ld_reqReady", 32'(reqReady), 0);
        step();
        checkOutput("ld_rspValid", 32'(rspValid), 1);
        checkOutput("ld_rspData", 32'(rspData), 32'h2AAAA);
        checkOutput("ld_rspDest", 32'(rspDest), 5);
        checkOutput("ld_rspIsLoad", 32'(rspIsLoad), 1);
        checkOutput("ld_rspError", 32'(rspError), 0);
        step();

        // Negative offset: 5 + (-5) = address 0
        applyStimulus(0, 1, 18'h00005, 6'b111011, 18'h33333, 4'd1);
        checkOutput("neg_memStr", 32'(memStr), 1);
        checkOutput("neg_memAddress", 32'(memAddress), 0);
        step();
        checkOutput("neg_rspError", 32'(rspError), 0);
        step();
        applyStimulus(0, 0, 18'h00005, 6'b111011, 18'h0, 4'd2);
        step();
        checkOutput("neg_ldData", 32'(rspData), 32'h33333);
        checkOutput("neg_ldError", 32'(rspError), 0);
        step();

        // 5 + (-6) wraps to 0x3FFFF: error, no write, response in cycle 1
        applyStimulus(0, 1, 18'h00005, 6'b111010, 18'h11111, 4'd4);
        checkOutput("wrap_rspValid", 32'(rspValid), 1);
        checkOutput("wrap_rspError", 32'(rspError), 1);
        checkOutput("wrap_rspData", 32'(rspData), 0);
        checkOutput("wrap_rspIsLoad", 32'(rspIsLoad), 0);
        checkOutput("wrap_memStr", 32'(memStr), 0);
        step();
        checkOutput("wrap_writeCount", 32'(writeCount), 2);
        checkOutput("wrap_idle", 32'(rspValid), 0);

        // 0x3FFFF + (-1) = 0x3FFFE: still out of range
        applyStimulus(0, 1, 18'h3FFFF, 6'h3F, 18'h11111, 4'd4);
        checkOutput("top_rspError", 32'(rspError), 1);
        checkOutput("top_memStr", 32'(memStr), 0);
        step();

        // Out-of-range load at base 0x400
        applyStimulus(0, 0, 18'h00400, 6'd0, 18'h0, 4'd7);
        checkOutput("oor_rspValid", 32'(rspValid), 1);
        checkOutput("oor_rspError", 32'(rspError), 1);
        checkOutput("oor_rspIsLoad", 32'(rspIsLoad), 1);
        checkOutput("oor_rspDest", 32'(rspDest), 7);
        checkOutput("oor_rspData", 32'(rspData), 0);
        checkOutput("oor_memStr", 32'(memStr), 0);
        step();
        checkOutput("oor_writeCount", 32'(writeCount), 2);

        // Backpressure: load of address 0 held in RESP for 5 cycles, a competing store is ignored
        rspReady = 1'b0;
        applyStimulus(0, 0, 18'h00005, 6'b111011, 18'h0, 4'd9);
        step();
        reqValid = 1'b1; reqWrite = 1'b1; reqBase = 18'h00010; reqOffset = 6'd2;
        reqStoreData = 18'h00001; reqDest = 4'd1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_rspValid", 32'(rspValid), 1);
            checkOutput("bp_rspData", 32'(rspData), 32'h33333);
            checkOutput("bp_rspDest", 32'(rspDest), 9);
            checkOutput("bp_rspIsLoad", 32'(rspIsLoad), 1);
            checkOutput("bp_reqReady", 32'(reqReady), 0);
            checkOutput("bp_memStr", 32'(memStr), 0);
            step();
        end
        reqValid = 1'b0;
        rspReady = 1'b1;
        step();
        checkOutput("bp_releaseValid", 32'(rspValid), 0);
        checkOutput("bp_releaseReady", 32'(reqReady), 1);
        checkOutput("bp_writeCount", 32'(writeCount), 2);
        checkOutput("bp_memAddress", 32'(memAddress), 0);

        // Reset during WRITE: the pending store must not land
        applyStimulus(0, 1, 18'h00010, 6'd2, 18'h15555, 4'd6);
        checkOutput("rw_memStrBefore", 32'(memStr), 1);
        reset = 1'b1;
        #1;
        checkOutput("rw_memStrInReset", 32'(memStr), 0);
        step();
        reset = 1'b0;
        checkOutput("rw_rspValid", 32'(rspValid), 0);
        checkOutput("rw_reqReady", 32'(reqReady), 1);
        checkOutput("rw_memKept", 32'(memFast[10'h012]), 32'h2AAAA);
        checkOutput("rw_writeCount", 32'(writeCount), 2);
        applyStimulus(0, 0, 18'h00010, 6'd2, 18'h0, 4'd6);
        step();
        checkOutput("rw_readBack", 32'(rspData), 32'h2AAAA);
        step();

        // Latency-3 instance: two stores, then a load that only sees its data in cycle 3
        applyStimulus(1, 1, 18'h00100, 6'd0, 18'h0ABCD, 4'd2);
        step();
        step();
        applyStimulus(1, 1, 18'h00200, 6'd0, 18'h01234, 4'd3);
        step();
        step();
        applyStimulus(1, 0, 18'h00100, 6'd0, 18'h0, 4'd4);
        for (int i = 0; i < 3; i++) begin
            checkOutput("l3_rspValidWait", 32'(rspValid3), 0);
            checkOutput("l3_memAddress", 32'(memAddress3), 32'h100);
            checkOutput("l3_memStr", 32'(memStr3), 0);
            step();
        end
        checkOutput("l3_rspValid", 32'(rspValid3), 1);
        checkOutput("l3_rspData", 32'(rspData3), 32'h0ABCD);
        checkOutput("l3_rspDest", 32'(rspDest3), 4);
        checkOutput("l3_rspIsLoad", 32'(rspIsLoad3), 1);
        step();
        checkOutput("l3_idle", 32'(reqReady3), 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
